// File: rtl/m8_bank_ctrl.sv
// m8_bank_ctrl: ping-pong bank controller between a word source and the M8 frame generator.
// The source fills one half of a 2x(2**AW) word RAM while M8 reads the other half.
// Banks swap when M8 toggles iSwitch. The controller tracks full flags, throttles the writer
// and reports underruns when M8 enters a bank that has not been completely written.
module m8_bank_ctrl #(
  parameter int AW     = 10,
  parameter int DW     = 12,
  parameter int UCNT_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              iSwitch,
  input  logic              iRdEn,
  input  logic [AW-1:0]     iAddr,
  input  logic              iWrValid,
  input  logic [DW-1:0]     iWrData,
  input  logic              iFlush,
  output logic              oWrReady,
  output logic              oMemWe,
  output logic [AW:0]       oMemWAddr,
  output logic [DW-1:0]     oMemWData,
  output logic              oMemRdEn,
  output logic [AW:0]       oMemRAddr,
  output logic [1:0]        oFull,
  output logic              oWrBank,
  output logic              oUnderrun,
  output logic [UCNT_W-1:0] oUnderCnt
);

  localparam logic [0:0] ST_FILL = 1'b0;
  localparam logic [0:0] ST_WAIT = 1'b1;

  localparam logic [AW-1:0]     PTR_LAST = '1;
  localparam logic [AW-1:0]     PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [UCNT_W-1:0] CNT_MAX  = '1;
  localparam logic [UCNT_W-1:0] CNT_ONE  = {{(UCNT_W-1){1'b0}}, 1'b1};

  logic [0:0]        state_q, state_d;
  logic              wr_bank_q, wr_bank_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [1:0]        full_q, full_d;
  logic              sw_prev_q, sw_prev_d;
  logic              rd_bank_q, rd_bank_d;
  logic              mem_we_q, mem_we_d;
  logic [AW:0]       mem_waddr_q, mem_waddr_d;
  logic [DW-1:0]     mem_wdata_q, mem_wdata_d;
  logic              underrun_q, underrun_d;
  logic [UCNT_W-1:0] under_cnt_q, under_cnt_d;

  logic sw_evt;
  logic in_fill;
  logic last_cand;
  logic abort_fill;
  logic wr_ready;
  logic hs;
  logic last_wr;
  logic other_bank;
  logic free_other;

  // Next-state logic: switch tracking, full-flag merge, writer FSM and write port.
  always_comb begin
    state_d     = state_q;
    wr_bank_d   = wr_bank_q;
    wr_ptr_d    = wr_ptr_q;
    full_d      = full_q;
    sw_prev_d   = iSwitch;
    rd_bank_d   = rd_bank_q;
    mem_we_d    = 1'b0;
    mem_waddr_d = mem_waddr_q;
    mem_wdata_d = mem_wdata_q;
    under_cnt_d = under_cnt_q;

    sw_evt  = iSwitch ^ sw_prev_q;
    in_fill = (state_q == ST_FILL);
    if (sw_evt) begin
      rd_bank_d = iSwitch;
    end

    // A word that completes the bank in the very cycle M8 enters it finishes that bank,
    // so it is not treated as an abort of a partial fill.
    last_cand  = in_fill && iWrValid && !iFlush && (wr_ptr_q == PTR_LAST);
    abort_fill = sw_evt && in_fill && (iSwitch == wr_bank_q) && !last_cand;
    wr_ready   = in_fill && !abort_fill && !iFlush;
    hs         = wr_ready && iWrValid;
    last_wr    = hs && (wr_ptr_q == PTR_LAST);

    // Set from a completing write first; a release of the same bank then wins.
    if (last_wr) begin
      full_d[wr_bank_q] = 1'b1;
    end
    if (sw_evt) begin
      full_d[rd_bank_q] = 1'b0;
    end

    // M8 reading a bank that is not full (after this cycle's completing write) is an underrun.
    underrun_d = sw_evt && !full_d[iSwitch];
    if (underrun_d && (under_cnt_q != CNT_MAX)) begin
      under_cnt_d = under_cnt_q + CNT_ONE;
    end

    other_bank = ~wr_bank_q;
    free_other = !full_d[other_bank] && (other_bank != rd_bank_d);

    if (hs) begin
      mem_we_d    = 1'b1;
      mem_waddr_d = {wr_bank_q, wr_ptr_q};
      mem_wdata_d = iWrData;
    end

    if (iFlush) begin
      full_d    = 2'b00;
      wr_ptr_d  = '0;
      wr_bank_d = ~rd_bank_d;
      state_d   = ST_FILL;
    end else begin
      case (state_q)
        ST_FILL: begin
          if (abort_fill) begin
            wr_ptr_d  = '0;
            wr_bank_d = ~iSwitch;
          end else if (hs) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (last_wr) begin
              if (free_other) begin
                wr_bank_d = other_bank;
              end else begin
                state_d = ST_WAIT;
              end
            end
          end
        end
        default: begin
          if (free_other) begin
            state_d   = ST_FILL;
            wr_bank_d = other_bank;
          end
        end
      endcase
    end
  end

  // State registers with synchronous reset; the switch trackers load the live iSwitch level.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_FILL;
      wr_bank_q   <= 1'b1;
      wr_ptr_q    <= '0;
      full_q      <= 2'b00;
      sw_prev_q   <= iSwitch;
      rd_bank_q   <= iSwitch;
      mem_we_q    <= 1'b0;
      mem_waddr_q <= '0;
      mem_wdata_q <= '0;
      underrun_q  <= 1'b0;
      under_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wr_bank_q   <= wr_bank_d;
      wr_ptr_q    <= wr_ptr_d;
      full_q      <= full_d;
      sw_prev_q   <= sw_prev_d;
      rd_bank_q   <= rd_bank_d;
      mem_we_q    <= mem_we_d;
      mem_waddr_q <= mem_waddr_d;
      mem_wdata_q <= mem_wdata_d;
      underrun_q  <= underrun_d;
      under_cnt_q <= under_cnt_d;
    end
  end

  assign oWrReady  = wr_ready;
  assign oMemWe    = mem_we_q;
  assign oMemWAddr = mem_waddr_q;
  assign oMemWData = mem_wdata_q;
  assign oMemRdEn  = iRdEn;
  assign oMemRAddr = {rd_bank_q, iAddr};
  assign oFull     = full_q;
  assign oWrBank   = wr_bank_q;
  assign oUnderrun = underrun_q;
  assign oUnderCnt = under_cnt_q;

endmodule

// File: tb/tb_m8_bank_ctrl.sv
// tb_m8_bank_ctrl: scoreboard bench for the ping-pong bank controller.
// Accepted words are pushed as {address, data} and popped when the registered write port fires.
module tb_m8_bank_ctrl;
  localparam int AW     = 10;
  localparam int DW     = 12;
  localparam int UCNT_W = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic              iSwitch;
  logic              iRdEn;
  logic [AW-1:0]     iAddr;
  logic              iWrValid;
  logic [DW-1:0]     iWrData;
  logic              iFlush;
  logic              oWrReady;
  logic              oMemWe;
  logic [AW:0]       oMemWAddr;
  logic [DW-1:0]     oMemWData;
  logic              oMemRdEn;
  logic [AW:0]       oMemRAddr;
  logic [1:0]        oFull;
  logic              oWrBank;
  logic              oUnderrun;
  logic [UCNT_W-1:0] oUnderCnt;

  int n_checks = 0;
  int n_pass   = 0;
  logic [AW+DW:0] sb_q[$];

  m8_bank_ctrl #(.AW(AW), .DW(DW), .UCNT_W(UCNT_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .iSwitch   (iSwitch),
    .iRdEn     (iRdEn),
    .iAddr     (iAddr),
    .iWrValid  (iWrValid),
    .iWrData   (iWrData),
    .iFlush    (iFlush),
    .oWrReady  (oWrReady),
    .oMemWe    (oMemWe),
    .oMemWAddr (oMemWAddr),
    .oMemWData (oMemWData),
    .oMemRdEn  (oMemRdEn),
    .oMemRAddr (oMemRAddr),
    .oFull     (oFull),
    .oWrBank   (oWrBank),
    .oUnderrun (oUnderrun),
    .oUnderCnt (oUnderCnt)
  );

  // 12.58 MHz-ish system clock
  always #40 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Offer one word; the expected acceptance is decided by the scenario, not by the DUT.
  task automatic write_word(input logic exp_ready, input logic [AW:0] exp_addr);
    iWrData  = DW'($urandom_range(0, (1 << DW) - 1));
    iWrValid = 1'b1;
    @(negedge clk);
    chk("wr_ready", 32'(oWrReady), 32'(exp_ready));
    if (exp_ready) sb_q.push_back({exp_addr, iWrData});
    @(posedge clk);
    #1;
    iWrValid = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Write-port monitor: every RAM write must match the oldest outstanding accepted word.
  always @(negedge clk) begin
    if (!reset && oMemWe) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_write", 32'(oMemWAddr), 32'h7fff_ffff);
      end else begin
        logic [AW+DW:0] e;
        e = sb_q.pop_front();
        $display("write addr=0x%03h data=0x%03h exp_addr=0x%03h exp_data=0x%03h",
                 oMemWAddr, oMemWData, e[AW+DW:DW], e[DW-1:0]);
        chk("waddr", 32'(oMemWAddr), 32'(e[AW+DW:DW]));
        chk("wdata", 32'(oMemWData), 32'(e[DW-1:0]));
      end
    end
  end

  // Watchdog: the scenario is fixed-length, this only guards against a stuck simulator.
  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset    = 1'b1;
    iSwitch  = 1'b0;
    iRdEn    = 1'b0;
    iAddr    = 10'd7;
    iWrValid = 1'b0;
    iWrData  = '0;
    iFlush   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_full", 32'(oFull), 32'd0);
    chk("rst_ready", 32'(oWrReady), 32'd1);
    chk("rst_wrbank", 32'(oWrBank), 32'd1);
    chk("rst_ucnt", 32'(oUnderCnt), 32'd0);
    chk("rst_under", 32'(oUnderrun), 32'd0);
    chk("rst_we", 32'(oMemWe), 32'd0);
    chk("rst_waddr", 32'(oMemWAddr), 32'd0);
    chk("rst_raddr", 32'(oMemRAddr), 32'h007);
    next_cycle();

    // 1: fill bank 1 completely, writer must stall in WAIT
    for (int i = 0; i < 1024; i++) write_word(1'b1, 11'(11'h400 + i));
    @(negedge clk);
    chk("t1_full", 32'(oFull), 32'd2);
    chk("t1_ready", 32'(oWrReady), 32'd0);
    chk("t1_wrbank", 32'(oWrBank), 32'd1);
    next_cycle();
    write_word(1'b0, 11'h000);

    // 2: M8 moves to bank 1, writer resumes in bank 0
    iSwitch = 1'b1;
    @(negedge clk);
    chk("t2_raddr_pre", 32'(oMemRAddr), 32'h007);
    next_cycle();
    @(negedge clk);
    chk("t2_under", 32'(oUnderrun), 32'd0);
    chk("t2_raddr", 32'(oMemRAddr), 32'h407);
    chk("t2_wrbank", 32'(oWrBank), 32'd0);
    chk("t2_ready", 32'(oWrReady), 32'd1);
    next_cycle();
    for (int i = 0; i < 500; i++) write_word(1'b1, 11'(i));
    @(negedge clk);
    chk("t2_full", 32'(oFull), 32'd2);
    next_cycle();

    // 3: M8 enters the half-written bank 0 -> underrun, fill restarts in bank 1
    iSwitch = 1'b0;
    write_word(1'b0, 11'h000);
    @(negedge clk);
    chk("t3_under", 32'(oUnderrun), 32'd1);
    chk("t3_ucnt", 32'(oUnderCnt), 32'd1);
    chk("t3_full", 32'(oFull), 32'd0);
    chk("t3_wrbank", 32'(oWrBank), 32'd1);
    next_cycle();
    @(negedge clk);
    chk("t3_under_pulse", 32'(oUnderrun), 32'd0);
    next_cycle();
    for (int i = 0; i < 1023; i++) write_word(1'b1, 11'(11'h400 + i));

    // 4: last word of bank 1 lands in the same cycle M8 switches to bank 1
    iSwitch = 1'b1;
    write_word(1'b1, 11'h7ff);
    @(negedge clk);
    chk("t4_full", 32'(oFull), 32'd2);
    chk("t4_under", 32'(oUnderrun), 32'd0);
    chk("t4_ucnt", 32'(oUnderCnt), 32'd1);
    chk("t4_ready", 32'(oWrReady), 32'd1);
    chk("t4_wrbank", 32'(oWrBank), 32'd0);
    next_cycle();

    // 6: flush mid-fill with a word offered
    for (int i = 0; i < 10; i++) write_word(1'b1, 11'(i));
    iFlush = 1'b1;
    write_word(1'b0, 11'h000);
    iFlush = 1'b0;
    @(negedge clk);
    chk("t6_full", 32'(oFull), 32'd0);
    chk("t6_wrbank", 32'(oWrBank), 32'd0);
    chk("t6_we", 32'(oMemWe), 32'd0);
    chk("t6_ucnt", 32'(oUnderCnt), 32'd1);
    next_cycle();
    write_word(1'b1, 11'h000);
    next_cycle();

    // 5: drive underruns up to and past counter saturation
    for (int k = 0; k < 253; k++) begin
      iSwitch = ~iSwitch;
      next_cycle();
    end
    @(negedge clk);
    chk("t5_ucnt_254", 32'(oUnderCnt), 32'd254);
    chk("t5_under", 32'(oUnderrun), 32'd1);
    next_cycle();
    for (int k = 0; k < 47; k++) begin
      iSwitch = ~iSwitch;
      next_cycle();
    end
    iRdEn = 1'b1;
    @(negedge clk);
    chk("t5_ucnt_sat", 32'(oUnderCnt), 32'd255);
    chk("rd_en", 32'(oMemRdEn), 32'd1);
    next_cycle();
    iRdEn = 1'b0;
    next_cycle();
    @(negedge clk);
    chk("t5_ucnt_hold", 32'(oUnderCnt), 32'd255);
    chk("t5_under_end", 32'(oUnderrun), 32'd0);

    repeat (2) next_cycle();
    chk("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
